// File: rtl/pc_unit_ds_if.sv
// Control/target inputs and fetch-address outputs of the program-counter unit.
// The decode/ALU side holds the master modport; the PC unit holds the slave.
interface pc_unit_ds_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             Jump;
    logic             JumpReg;
    logic             Branch;
    logic [2:0]       BrCond;
    logic             ALUZero;
    logic             ALUNeg;
    logic [25:0]      JumpTarget;
    logic [WIDTH-1:0] BranchOffset;
    logic [WIDTH-1:0] RegTarget;
    logic             Exception;
    logic             Eret;
    logic [WIDTH-1:0] PCOut;
    logic [WIDTH-1:0] NextPC;
    logic [WIDTH-1:0] EPC;
    logic             InDelaySlot;

    modport master (
        output Stall, Jump, JumpReg, Branch, BrCond, ALUZero, ALUNeg,
               JumpTarget, BranchOffset, RegTarget, Exception, Eret,
        input  PCOut, NextPC, EPC, InDelaySlot
    );

    modport slave (
        input  Stall, Jump, JumpReg, Branch, BrCond, ALUZero, ALUNeg,
               JumpTarget, BranchOffset, RegTarget, Exception, Eret,
        output PCOut, NextPC, EPC, InDelaySlot
    );
endinterface

// File: rtl/pc_unit_ds.sv
// Program-counter unit: reset/exception vectors, EPC/ERET, stall, six branch
// conditions, J/JR, and an optional one-instruction branch delay slot.
module pc_unit_ds #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int          DELAY_SLOT   = 0
) (
    input  logic        CLK,
    input  logic        RST,
    pc_unit_ds_if.slave bus
);
    typedef enum logic {
        RUN  = 1'b0,
        SLOT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);
    localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(3);
    localparam bit USE_SLOT = (DELAY_SLOT != 0);

    state_t           stateReg, stateNext;
    logic [WIDTH-1:0] pcReg, pcNext;
    logic [WIDTH-1:0] epcReg, epcNext;
    logic [WIDTH-1:0] pendingReg, pendingNext;
    logic             inSlotReg, inSlotNext;

    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] jumpAddr;
    logic [WIDTH-1:0] branchAddr;
    logic [WIDTH-1:0] regAddr;
    logic [WIDTH-1:0] redirectTarget;
    logic             condHolds;
    logic             taken;
    logic             redirect;

    assign pc4        = pcReg + FOUR;
    assign jumpAddr   = {pc4[WIDTH-1:28], bus.JumpTarget, 2'b00};
    assign branchAddr = pc4 + (bus.BranchOffset << 2);
    assign regAddr    = bus.RegTarget & WORD_MASK;

    always_comb begin
        condHolds = 1'b0;
        unique case (bus.BrCond)
            3'b000:  condHolds = bus.ALUZero;
            3'b001:  condHolds = !bus.ALUZero;
            3'b010:  condHolds = bus.ALUNeg || bus.ALUZero;
            3'b011:  condHolds = !bus.ALUNeg && !bus.ALUZero;
            3'b100:  condHolds = bus.ALUNeg;
            3'b101:  condHolds = !bus.ALUNeg;
            default: condHolds = 1'b0;
        endcase
    end

    assign taken    = bus.Branch && condHolds;
    assign redirect = bus.JumpReg || bus.Jump || taken;

    always_comb begin
        redirectTarget = branchAddr;
        if (bus.JumpReg) begin
            redirectTarget = regAddr;
        end else if (bus.Jump) begin
            redirectTarget = jumpAddr;
        end
    end

    // Reset is folded in here too so NextPC shows the reset vector while RST is high.
    always_comb begin
        stateNext   = stateReg;
        pcNext      = pcReg;
        epcNext     = epcReg;
        pendingNext = pendingReg;
        inSlotNext  = inSlotReg;

        if (RST) begin
            stateNext   = RUN;
            pcNext      = RESET_PC;
            epcNext     = '0;
            pendingNext = '0;
            inSlotNext  = 1'b0;
        end else if (bus.Exception) begin
            // In SLOT the faulting delay-slot instruction restarts at its branch.
            epcNext     = (stateReg == SLOT) ? (pcReg - FOUR) : pcReg;
            pcNext      = EXC_PC;
            stateNext   = RUN;
            pendingNext = '0;
            inSlotNext  = 1'b0;
        end else if (bus.Stall) begin
            stateNext = stateReg;
        end else if (bus.Eret) begin
            pcNext     = epcReg;
            stateNext  = RUN;
            inSlotNext = 1'b0;
        end else if (stateReg == SLOT) begin
            pcNext     = pendingReg;
            stateNext  = RUN;
            inSlotNext = 1'b0;
        end else if (redirect) begin
            if (USE_SLOT) begin
                pendingNext = redirectTarget;
                pcNext      = pc4;
                inSlotNext  = 1'b1;
                stateNext   = SLOT;
            end else begin
                pcNext = redirectTarget;
            end
        end else begin
            pcNext = pc4;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg   <= RUN;
            pcReg      <= RESET_PC;
            epcReg     <= '0;
            pendingReg <= '0;
            inSlotReg  <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            epcReg     <= epcNext;
            pendingReg <= pendingNext;
            inSlotReg  <= inSlotNext;
        end
    end

    assign bus.PCOut       = pcReg;
    assign bus.NextPC      = pcNext;
    assign bus.EPC         = epcReg;
    assign bus.InDelaySlot = inSlotReg;
endmodule

// File: tb/tb_pc_unit_ds.sv
// Bench for pc_unit_ds: two instances (no delay slot / delay slot) driven in
// lockstep and compared against a behavioural model, plus directed scenarios.
module tb_pc_unit_ds;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    pc_unit_ds_if #(.WIDTH(32)) bus0 ();
    pc_unit_ds_if #(.WIDTH(32)) bus1 ();

    pc_unit_ds #(.WIDTH(32), .DELAY_SLOT(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    pc_unit_ds #(.WIDTH(32), .DELAY_SLOT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    typedef struct packed {
        bit        rst;
        bit        stall;
        bit        jump;
        bit        jumpReg;
        bit        branch;
        bit [2:0]  brCond;
        bit        aluZero;
        bit        aluNeg;
        bit [25:0] jumpTarget;
        bit [31:0] branchOffset;
        bit [31:0] regTarget;
        bit        exception;
        bit        eret;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        slot;
        logic [31:0] pending;
        logic        inSlot;
    } mstate_t;

    int testsRun = 0;
    int testsFailed = 0;
    bit modelValid = 1'b0;
    mstate_t m0, m1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit condOk(input bit [2:0] cond, input bit z, input bit n);
        case (cond)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return n || z;
            3'd3:    return !n && !z;
            3'd4:    return n;
            3'd5:    return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Expected state after one edge, from the architectural rules.
    function automatic mstate_t modelNext(input mstate_t s, input ctrl_t c, input bit ds);
        mstate_t     n = s;
        logic [31:0] pc4 = s.pc + 32'd4;
        logic [31:0] target;
        bit          isRedirect;
        if (c.jumpReg)   target = {c.regTarget[31:2], 2'b00};
        else if (c.jump) target = {pc4[31:28], 28'h0} | (32'(c.jumpTarget) * 4);
        else             target = pc4 + c.branchOffset * 4;
        isRedirect = c.jumpReg || c.jump || (c.branch && condOk(c.brCond, c.aluZero, c.aluNeg));
        if (c.rst) begin
            n = '{pc: 32'h3000, epc: 32'h0, slot: 1'b0, pending: 32'h0, inSlot: 1'b0};
        end else if (c.exception) begin
            n.epc = s.slot ? s.pc - 32'd4 : s.pc;
            n.pc = 32'h4180;
            n.slot = 1'b0;
            n.inSlot = 1'b0;
            n.pending = 32'h0;
        end else if (c.stall) begin
            n = s;
        end else if (c.eret) begin
            n.pc = s.epc;
            n.slot = 1'b0;
            n.inSlot = 1'b0;
        end else if (s.slot) begin
            n.pc = s.pending;
            n.slot = 1'b0;
            n.inSlot = 1'b0;
        end else if (isRedirect && ds) begin
            n.pending = target;
            n.pc = pc4;
            n.slot = 1'b1;
            n.inSlot = 1'b1;
        end else if (isRedirect) begin
            n.pc = target;
        end else begin
            n.pc = pc4;
        end
        return n;
    endfunction

    task automatic drive(input ctrl_t c);
        RST = c.rst;
        bus0.Stall = c.stall;         bus1.Stall = c.stall;
        bus0.Jump = c.jump;           bus1.Jump = c.jump;
        bus0.JumpReg = c.jumpReg;     bus1.JumpReg = c.jumpReg;
        bus0.Branch = c.branch;       bus1.Branch = c.branch;
        bus0.BrCond = c.brCond;       bus1.BrCond = c.brCond;
        bus0.ALUZero = c.aluZero;     bus1.ALUZero = c.aluZero;
        bus0.ALUNeg = c.aluNeg;       bus1.ALUNeg = c.aluNeg;
        bus0.JumpTarget = c.jumpTarget;     bus1.JumpTarget = c.jumpTarget;
        bus0.BranchOffset = c.branchOffset; bus1.BranchOffset = c.branchOffset;
        bus0.RegTarget = c.regTarget;       bus1.RegTarget = c.regTarget;
        bus0.Exception = c.exception; bus1.Exception = c.exception;
        bus0.Eret = c.eret;           bus1.Eret = c.eret;
    endtask

    // One clock: drive at negedge, check NextPC, then check registered outputs after the edge.
    task automatic cycle(input ctrl_t c);
        mstate_t n0, n1;
        @(negedge CLK);
        drive(c);
        #1;
        n0 = modelNext(m0, c, 1'b0);
        n1 = modelNext(m1, c, 1'b1);
        if (modelValid || c.rst) begin
            check("nextpc_ds0", bus0.NextPC, n0.pc);
            check("nextpc_ds1", bus1.NextPC, n1.pc);
        end
        @(posedge CLK);
        #1;
        m0 = n0;
        m1 = n1;
        if (c.rst) modelValid = 1'b1;
        if (modelValid) begin
            check("pc_ds0", bus0.PCOut, m0.pc);
            check("epc_ds0", bus0.EPC, m0.epc);
            check("slot_ds0", bus0.InDelaySlot, m0.inSlot);
            check("pc_ds1", bus1.PCOut, m1.pc);
            check("epc_ds1", bus1.EPC, m1.epc);
            check("slot_ds1", bus1.InDelaySlot, m1.inSlot);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0);
    endtask

    task automatic doReset();
        ctrl_t c = '0;
        c.rst = 1'b1;
        cycle(c);
    endtask

    function automatic ctrl_t mkBranch(input bit [2:0] cond, input bit z, input bit n, input bit [31:0] off);
        ctrl_t c = '0;
        c.branch = 1'b1;
        c.brCond = cond;
        c.aluZero = z;
        c.aluNeg = n;
        c.branchOffset = off;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl_t c;
        m0 = '0;
        m1 = '0;
        drive('0);

        // Reset and sequential fetch
        doReset();
        check("reset_pc", bus0.PCOut, 32'h3000);
        check("reset_epc", bus0.EPC, 32'h0);
        check("reset_slot", bus1.InDelaySlot, 1'b0);
        idle(1); check("seq_3004", bus0.PCOut, 32'h3004);
        idle(1); check("seq_3008", bus0.PCOut, 32'h3008);
        idle(1); check("seq_300c", bus0.PCOut, 32'h300C);

        // Branch conditions without delay slot
        doReset(); cycle(mkBranch(3'b000, 1'b1, 1'b0, 32'h10));
        check("beq_taken", bus0.PCOut, 32'h3044);
        doReset(); cycle(mkBranch(3'b001, 1'b1, 1'b0, 32'h10));
        check("bne_not_taken", bus0.PCOut, 32'h3004);
        doReset(); cycle(mkBranch(3'b011, 1'b0, 1'b0, 32'h10));
        check("bgtz_taken", bus0.PCOut, 32'h3044);
        doReset(); cycle(mkBranch(3'b110, 1'b1, 1'b1, 32'h10));
        check("cond110_never", bus0.PCOut, 32'h3004);

        // Jump priority
        doReset(); idle(4);
        c = '0; c.jump = 1'b1; c.jumpReg = 1'b1; c.regTarget = 32'h5003; c.jumpTarget = 26'h400;
        cycle(c);
        check("jr_over_j", bus0.PCOut, 32'h5000);
        doReset(); idle(4);
        c.jumpReg = 1'b0;
        cycle(c);
        check("j_target", bus0.PCOut, 32'h1000);

        // Delay slot
        doReset(); cycle(mkBranch(3'b000, 1'b1, 1'b0, 32'h4));
        check("ds_slot_pc", bus1.PCOut, 32'h3004);
        check("ds_slot_flag", bus1.InDelaySlot, 1'b1);
        idle(1);
        check("ds_target_pc", bus1.PCOut, 32'h3014);
        check("ds_target_flag", bus1.InDelaySlot, 1'b0);
        doReset(); cycle(mkBranch(3'b000, 1'b1, 1'b0, 32'h4));
        c = '0; c.exception = 1'b1;
        cycle(c);
        check("ds_exc_epc", bus1.EPC, 32'h3000);
        check("ds_exc_pc", bus1.PCOut, 32'h4180);
        idle(1);
        check("ds_exc_discard", bus1.PCOut, 32'h4184);

        // Stall interaction
        doReset();
        c = '0; c.stall = 1'b1; c.jump = 1'b1; c.jumpTarget = 26'h400;
        cycle(c); cycle(c);
        check("stall_pc", bus0.PCOut, 32'h3000);
        check("stall_nextpc", bus0.NextPC, 32'h3000);
        c = '0; c.stall = 1'b1; c.exception = 1'b1;
        cycle(c);
        check("stall_exc_pc", bus0.PCOut, 32'h4180);
        check("stall_exc_epc", bus0.EPC, 32'h3000);
        c = '0; c.stall = 1'b1; c.eret = 1'b1;
        cycle(c);
        check("stall_eret_ignored", bus0.PCOut, 32'h4180);
        c.stall = 1'b0;
        cycle(c);
        check("eret_pc", bus0.PCOut, 32'h3000);

        // Reset while in SLOT, then wrap-around
        doReset(); cycle(mkBranch(3'b101, 1'b0, 1'b0, 32'h40));
        doReset();
        check("rst_slot_pc", bus1.PCOut, 32'h3000);
        check("rst_slot_flag", bus1.InDelaySlot, 1'b0);
        idle(1);
        check("rst_slot_run", bus1.PCOut, 32'h3004);
        c = '0; c.jumpReg = 1'b1; c.regTarget = 32'hFFFF_FFFF;
        cycle(c);
        check("wrap_top", bus0.PCOut, 32'hFFFF_FFFC);
        idle(1);
        check("wrap_zero", bus0.PCOut, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            c = '0;
            c.rst = ($urandom_range(0, 199) == 0);
            c.exception = ($urandom_range(0, 99) < 3);
            c.eret = ($urandom_range(0, 99) < 5);
            c.stall = ($urandom_range(0, 99) < 15);
            c.jump = ($urandom_range(0, 99) < 10);
            c.jumpReg = ($urandom_range(0, 99) < 8);
            c.branch = ($urandom_range(0, 99) < 30);
            c.brCond = 3'($urandom_range(0, 7));
            c.aluZero = 1'($urandom_range(0, 1));
            c.aluNeg = 1'($urandom_range(0, 1));
            c.jumpTarget = 26'($urandom);
            c.branchOffset = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
            c.regTarget = $urandom;
            cycle(c);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/pc_unit_ds.md
Name: pc_unit_ds

Overview:
- Parametrised next-generation program-counter unit for the MIPS core; drives the instruction-fetch address.
- Adds over the current PC unit:
  - a synchronous reset vector;
  - a fetch stall;
  - six branch conditions;
  - jump-register;
  - an exception vector with EPC capture and ERET return;
  - an optional one-instruction branch delay slot, handled by a two-state FSM.
- Sits between the decode/ALU control signals and instruction memory.

Parameters:
- WIDTH, 32, PC/address width; legal range 32..64.
- RESET_VECTOR, 32'h0000_3000, PC value after reset (zero-extended to WIDTH).
- EXC_VECTOR, 32'h0000_4180, PC value loaded on exception (zero-extended to WIDTH).
- DELAY_SLOT, 0, 0 = redirect takes effect on the next fetch; 1 = MIPS delay-slot semantics.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Stall  in  1  hold PC and FSM this cycle.
- Jump  in  1  J/JAL: target from JumpTarget.
- JumpReg  in  1  JR/JALR: target from RegTarget.
- Branch  in  1  conditional branch under BrCond.
- BrCond  in  3  000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 LTZ, 101 GEZ, 11x never taken.
- ALUZero  in  1  compare result zero.
- ALUNeg  in  1  compare operand negative.
- JumpTarget  in  26  instr_index field.
- BranchOffset  in  WIDTH  sign-extended word offset.
- RegTarget  in  WIDTH  register jump target.
- Exception  in  1  take exception this cycle.
- Eret  in  1  return from exception.
- PCOut  out  WIDTH  current fetch address (registered).
- NextPC  out  WIDTH  value PCOut will take at the next edge (combinational, for prefetch).
- EPC  out  WIDTH  exception return address (registered).
- InDelaySlot  out  1  PCOut is a delay-slot instruction (registered).

Behaviour:
- Reset (RST=1 at an edge): PCOut=RESET_VECTOR, EPC=0, InDelaySlot=0, FSM=RUN, pending target=0. RST overrides every other input.
- Address arithmetic:
  - PC4 = PCOut+4, mod 2^WIDTH.
  - JumpAddr = {PC4[WIDTH-1:28], JumpTarget, 2'b00}.
  - BranchAddr = PC4 + (BranchOffset<<2), mod 2^WIDTH.
  - RegAddr = {RegTarget[WIDTH-1:2], 2'b00}.
- Branch taken (Taken):
  - Branch=1 and the condition holds.
  - EQ: ALUZero. NE: !ALUZero. LEZ: ALUNeg|ALUZero. GTZ: !ALUNeg&!ALUZero. LTZ: ALUNeg. GEZ: !ALUNeg.
- Redirect target priority: JumpReg > Jump > Taken branch. Redirect = JumpReg|Jump|Taken.
- Per-edge priority when not in reset:
  1. Exception: EPC<=PCOut in RUN, or PCOut-4 in SLOT (the branch address). PCOut<=EXC_VECTOR; FSM<=RUN; InDelaySlot<=0; pending target discarded. Exception ignores Stall.
  2. Stall=1: all state holds. Eret is ignored that cycle.
  3. Eret: PCOut<=EPC; FSM<=RUN; InDelaySlot<=0.
  4. Normal sequencing, per FSM below.
- FSM when DELAY_SLOT=0: always RUN. On Redirect, PCOut<=target; otherwise PCOut<=PC4. InDelaySlot is constant 0.
- FSM when DELAY_SLOT=1:
  - RUN, Redirect: pending<=target; PCOut<=PC4; InDelaySlot<=1; FSM<=SLOT.
  - RUN, no Redirect: PCOut<=PC4.
  - SLOT: PCOut<=pending; InDelaySlot<=0; FSM<=RUN. Jump/JumpReg/Branch are ignored in SLOT (control transfer in a delay slot is architecturally undefined; the block ignores it).
- NextPC: combinationally equals the value the priority chain will load at the next edge, including RESET_VECTOR when RST=1.
- Exception and Eret asserted together: Exception wins; EPC is overwritten.
- Wrap-around: PC4 at the top of the address space wraps to 0 with no error flag.
- Redirect with Stall=1: no effect. Decode must hold the control inputs until Stall deasserts.

Test Plan:
- Reset and sequential fetch: RST=1 for one edge, then 3 idle edges -> PCOut 0x3000, 0x3004, 0x3008, 0x300C; EPC=0.
- Branch conditions, DELAY_SLOT=0, PCOut=0x3000, BranchOffset=0x10:
  - BEQ with ALUZero=1 -> PCOut=0x3044.
  - BNE with ALUZero=1 -> 0x3004.
  - GTZ with ALUNeg=0, ALUZero=0 -> taken.
  - BrCond=110 -> never taken.
- Jump priority: at PCOut=0x3010, Jump=1, JumpReg=1, RegTarget=0x5003, JumpTarget=0x0000400 -> PCOut=0x5000. Repeat with JumpReg=0 -> PCOut=0x1000.
- Delay slot, DELAY_SLOT=1: taken BEQ at 0x3000, offset 4 -> PCOut 0x3004 with InDelaySlot=1, then 0x3014 with InDelaySlot=0. Exception during the 0x3004 cycle -> EPC=0x3000, PCOut=0x4180, target discarded.
- Stall interaction:
  - Stall=1 for 2 cycles with Jump held -> PCOut frozen; NextPC equals PCOut.
  - Exception while Stall=1 -> PCOut=0x4180 anyway.
  - Eret while Stall=1 -> ignored; Eret after Stall deasserts -> PCOut=EPC.
- Reset mid-operation and wrap: RST asserted while in SLOT -> PCOut=0x3000, FSM RUN, InDelaySlot=0. With WIDTH=32 and PCOut=0xFFFF_FFFC, one idle edge -> PCOut=0x0000_0000.
